// File: rtl/alu_uart_pkg.sv
// Shared types and framing constants for the ALU result UART transmitter.
// Imported by the transmitter top and by anything that decodes its debug state.
package alu_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Result handshake from the ALU: a transfer happens on an edge where
// res_valid && res_ready; res_data must be stable whenever res_valid is high.
interface alu_result_uart_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready
  );

endinterface

// File: rtl/alu_result_uart_tx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when empty
// are ignored so callers may drive them without guarding.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index but different wrap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Buffers ALU results and sends each one as an 8N1 frame on tx, LSB first,
// flagging results offered while the buffer is full.
module alu_result_uart_tx
  import alu_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  alu_result_uart_tx_if.slave         res,
  input  logic                        clr_ovf,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ovf_flag,
  output tx_state_t                   dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]    BAUD_LAST = 8'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  tx_state_t         state, state_n;
  logic [7:0]        baud_cnt, baud_n;
  logic [BW-1:0]     bit_idx, bit_n;
  logic [DATA_W-1:0] shifter, shifter_n;
  logic              tx_n;
  logic              bit_done;
  logic              push, pop;
  logic              full, empty;
  logic [DATA_W-1:0] head;

  assign res.res_ready = !full;
  assign push          = res.res_valid && !full;
  assign bit_done      = (baud_cnt == BAUD_LAST);
  assign busy          = (state != IDLE) || (fifo_count != '0);
  assign dbg_state     = state;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (res.res_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // tx_n is the line level for the cycle after this edge, so tx stays a clean flop output.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    shifter_n = shifter;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = STOP_BIT;
        if (!empty) begin
          pop       = 1'b1;
          shifter_n = head;
          baud_n    = '0;
          tx_n      = START_BIT;
          state_n   = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shifter[0];
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 8'd1;
          tx_n   = START_BIT;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == BIT_LAST) begin
            tx_n    = STOP_BIT;
            state_n = STOP;
          end else begin
            bit_n     = bit_idx + 1'b1;
            shifter_n = shifter >> 1;
            tx_n      = shifter[1];
          end
        end else begin
          baud_n = baud_cnt + 8'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (!empty) begin
            pop       = 1'b1;
            shifter_n = head;
            tx_n      = START_BIT;
            state_n   = START;
          end else begin
            tx_n    = STOP_BIT;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 8'd1;
          tx_n   = STOP_BIT;
        end
      end
      default: begin
        tx_n    = STOP_BIT;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= STOP_BIT;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shifter  <= shifter_n;
      tx       <= tx_n;
    end
  end

  // A new overflow on the same edge as a clear request leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (res.res_valid && full) begin
      ovf_flag <= 1'b1;
    end else if (clr_ovf) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx: a queue-and-frame-timer model is
// compared on every falling edge, with literal checks pinning key cycles.
module tb_alu_result_uart_tx;
  import alu_uart_pkg::*;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       ovf_flag;
  tx_state_t  dbg_state;

  alu_result_uart_tx_if #(.DATA_W(DW)) bus ();

  alu_result_uart_tx #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH),
    .DATA_W     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .res        (bus.slave),
    .clr_ovf    (clr_ovf),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .ovf_flag   (ovf_flag),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: results waiting in a queue, plus one frame in flight timed by a cycle count.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  bit            m_active = 1'b0;
  int            m_cyc = 0;
  bit            m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    int pre;
    bit was_full;
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0;
      m_cyc    = 0;
      m_ovf    = 1'b0;
    end else begin
      pre      = exp_q.size();
      was_full = (pre == DEPTH);
      if (m_active) begin
        m_cyc++;
        if (m_cyc == FRAME_BITS * BD) begin
          if (pre != 0) begin
            m_data = exp_q.pop_front();
            m_cyc  = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (pre != 0) begin
        m_data   = exp_q.pop_front();
        m_active = 1'b1;
        m_cyc    = 0;
      end
      if (bus.res_valid && !was_full) exp_q.push_back(bus.res_data);
      if (bus.res_valid && was_full) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  function automatic int model_tx();
    int idx;
    if (!m_active) return 1;
    idx = m_cyc / BD;
    if (idx == 0) return 0;
    if (idx == FRAME_BITS - 1) return 1;
    return int'(m_data[idx-1]);
  endfunction

  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("tx",         int'(tx),         model_tx());
      check("busy",       int'(busy),       int'(m_active || exp_q.size() != 0));
      check("fifo_count", int'(fifo_count), exp_q.size());
      check("res_ready",  int'(bus.res_ready), int'(exp_q.size() < DEPTH));
      check("ovf_flag",   int'(ovf_flag),   int'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_en = 1'b1;

    // Quiet line after reset
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(bus.res_ready), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf", int'(ovf_flag), 0);
    repeat (50) tick();
    check("quiet_tx", int'(tx), 1);
    check("quiet_busy", int'(busy), 0);

    // Single 0xA5 frame: now at edge N (+2)
    push_one(8'hA5);
    check("a5_count_n", int'(fifo_count), 1);
    tick();                         // N+1
    check("a5_start_n1", int'(tx), 0);
    repeat (3) tick();              // N+4
    check("a5_start_n4", int'(tx), 0);
    tick();                         // N+5 bit0
    check("a5_bit0", int'(tx), 1);
    repeat (4) tick();              // N+9 bit1
    check("a5_bit1", int'(tx), 0);
    repeat (4) tick();              // N+13 bit2
    check("a5_bit2", int'(tx), 1);
    repeat (24) tick();             // N+37 stop
    check("a5_stop", int'(tx), 1);
    repeat (3) tick();              // N+40
    check("a5_busy_n40", int'(busy), 1);
    tick();                         // N+41
    check("a5_busy_n41", int'(busy), 0);
    check("a5_idle_state", int'(dbg_state == IDLE), 1);

    // Three back-to-back frames
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = 8'(i + 1);
      tick();
    end
    bus.res_valid = 1'b0;           // now at N+2
    check("b2b_count", int'(fifo_count), 2);
    repeat (38) tick();             // N+40 last stop cycle of frame 1
    check("b2b_stop1", int'(tx), 1);
    tick();                         // N+41 second start bit
    check("b2b_start2", int'(tx), 0);
    wait_idle(300);

    // Six offers: five accepted, sixth overflows
    for (int i = 0; i < 6; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = 8'(8'h10 + i);
      #1;
      if (i == 5) check("full_ready", int'(bus.res_ready), 0);
      tick();
    end
    bus.res_valid = 1'b0;
    check("ovf_set", int'(ovf_flag), 1);
    check("full_count", int'(fifo_count), 4);
    wait_idle(400);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", int'(ovf_flag), 0);

    // Clear and overflow on the same edge: set wins
    for (int i = 0; i < 6; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = 8'(8'h60 + i);
      clr_ovf       = (i == 5);
      tick();
    end
    bus.res_valid = 1'b0;
    clr_ovf       = 1'b0;
    check("ovf_set_wins", int'(ovf_flag), 1);
    wait_idle(400);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // Reset in the middle of a 0xFF data phase with one more result buffered
    push_one(8'hFF);                // N
    push_one(8'h3C);                // N+1
    repeat (13) tick();             // N+14
    check("pre_rst_count", int'(fifo_count), 1);
    check("pre_rst_state", int'(dbg_state == DATA), 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_count", int'(fifo_count), 0);
    check("rst_mid_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    repeat (50) tick();
    check("post_rst_tx", int'(tx), 1);
    check("post_rst_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
